axis_rr_pkt_arbiter: RTL and testbench
======================================

Name: axis_rr_pkt_arbiter

Overview:
- Packet-level round-robin arbiter that merges P_CH_NUM AXI-Stream channels (64-bit data, 80-bit user, 8-bit keep) onto one output stream.
- Sits in the TX path in front of the MAC/IP framer, where upstream sources (ARP, ICMP, UDP) compete for one egress.
- Uses full ready/valid backpressure with no internal packet FIFOs. A grant is held until the beat carrying last is accepted, so packets are never interleaved.
- Reports the granted channel and counts oversize packets for debug.

Parameters:
- P_CH_NUM, 2, number of input channels, legal range 2..4.
- P_MAX_BEATS, 256, beats per packet above which the oversize flag fires; 16-bit compare.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- s_axis_data  in  64*P_CH_NUM  channel i occupies bits [64i+63:64i].
- s_axis_user  in  80*P_CH_NUM  per-channel user (length/type), channel i at [80i+79:80i].
- s_axis_keep  in  8*P_CH_NUM  per-channel byte enables.
- s_axis_last  in  P_CH_NUM  per-channel end of packet.
- s_axis_valid  in  P_CH_NUM  per-channel valid.
- s_axis_ready  out  P_CH_NUM  per-channel ready.
- m_axis_out_data  out  64  merged data.
- m_axis_out_user  out  80  merged user; constant for the whole packet.
- m_axis_out_keep  out  8  merged keep.
- m_axis_out_last  out  1  merged last.
- m_axis_out_valid  out  1  merged valid.
- m_axis_out_ready  in  1  downstream ready.
- o_grant_id  out  2  currently or last granted channel.
- o_busy  out  1  high while a packet is locked.
- o_oversize_cnt  out  16  saturating count of packets exceeding P_MAX_BEATS.

Behaviour:
- Reset values: all m_axis_out_* = 0; s_axis_ready = 0; o_grant_id = 0; o_busy = 0; o_oversize_cnt = 0; state = IDLE; rr pointer = P_CH_NUM-1, so channel 0 wins first.
- Handshake:
  - A transfer occurs on any cycle where valid & ready.
  - m_axis_out_valid, once asserted, holds data/user/keep/last stable until m_axis_out_ready.
  - An input beat is never dropped or duplicated.
- State IDLE:
  - If any s_axis_valid[i]=1, grant = first requesting channel searching (ptr+1) mod N upward, with wrap.
  - On grant: ptr <= grant, o_grant_id <= grant, o_busy <= 1, state -> XFER.
  - If no channel is valid, stay in IDLE.
  - Arbitration costs exactly one cycle; s_axis_ready is all-zero in IDLE.
- State XFER:
  - s_axis_ready[grant] = (!m_axis_out_valid | m_axis_out_ready); all other ready bits = 0.
  - On an accepted input beat, the output register loads data/user/keep/last from the granted channel and sets m_axis_out_valid = 1.
  - Latency from input accept to output valid is 1 cycle.
  - If the output is accepted and no new input is accepted in the same cycle, m_axis_out_valid <= 0.
  - Accepted beat with last=1: state -> IDLE and o_busy <= 0 next cycle. The register may still hold that last beat; IDLE re-arbitration proceeds in parallel.
  - Full throughput within a packet is 1 beat/cycle when ready is continuously high. There is one idle bubble between packets.
- Requester behaviour:
  - A non-granted requester keeps valid high and is never starved: worst-case wait is N-1 packets.
  - Dropping valid in IDLE before the grant withdraws the request; no state is kept for it.
- Beat counter:
  - 16-bit counter, cleared on grant, incremented on each accepted input beat, saturating at 0xFFFF.
  - On the accepted last beat, if count (including that beat) > P_MAX_BEATS, o_oversize_cnt += 1, saturating at 0xFFFF.
  - The packet still passes through unchanged.
- Boundary cases:
  - Single-beat packet (valid and last on the first beat): grant, 1 beat, back to IDLE.
  - A granted channel that drops valid mid-packet stalls the arbiter with no timeout; the grant is held.
  - keep is passed through unmodified; user is sampled on every beat, and the source guarantees it is constant.
- Reset mid-packet: all state clears immediately, and the partial packet is abandoned on both sides.

Test Plan:
- Ch0 sends 4 beats (data 0x1..0x4, last on the 4th, keep=0x0F on the last), ready=1 throughout → output shows the same 4 beats starting 1 cycle after the first accept; last with keep=0x0F; o_grant_id=0; o_busy drops the cycle after last is accepted.
- Ch0 and ch1 both continuously valid with 3-beat packets, N=2 → output grant sequence 0,1,0,1; no interleaving; exactly one bubble between packets.
- N=4, channels 1 and 3 request, pointer=1 → ch3 granted next, then ch1; ch0 and ch2 ready bits stay 0.
- m_axis_out_ready toggles 1,0,0,1 during a 5-beat packet → no beat lost or duplicated; output data stable while ready=0; input ready deasserts while the output register is full and not accepted.
- P_MAX_BEATS=4, ch1 sends a 6-beat packet then a 4-beat packet → o_oversize_cnt = 1 after the first, still 1 after the second; all 10 beats delivered.
- Assert i_rst in the 2nd beat of a 5-beat packet → all outputs 0 the same cycle; after release, ch0 wins the first grant.

Source files
------------

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-level round-robin arbiter: merges P_CH_NUM AXI-Stream channels onto one
// registered output stream, holding each grant until the last beat is accepted.
module axis_rr_pkt_arbiter #(
  parameter int unsigned P_CH_NUM    = 2,
  parameter int unsigned P_MAX_BEATS = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [64*P_CH_NUM-1:0]   s_axis_data,
  input  logic [80*P_CH_NUM-1:0]   s_axis_user,
  input  logic [8*P_CH_NUM-1:0]    s_axis_keep,
  input  logic [P_CH_NUM-1:0]      s_axis_last,
  input  logic [P_CH_NUM-1:0]      s_axis_valid,
  output logic [P_CH_NUM-1:0]      s_axis_ready,
  output logic [63:0]              m_axis_out_data,
  output logic [79:0]              m_axis_out_user,
  output logic [7:0]               m_axis_out_keep,
  output logic                     m_axis_out_last,
  output logic                     m_axis_out_valid,
  input  logic                     m_axis_out_ready,
  output logic [1:0]               o_grant_id,
  output logic                     o_busy,
  output logic [15:0]              o_oversize_cnt
);

  localparam int unsigned DW = 64;
  localparam int unsigned UW = 80;
  localparam int unsigned KW = 8;
  localparam int unsigned GW = 2;
  localparam int unsigned CW = 16;

  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   data_q, data_d;
  logic [UW-1:0]   user_q, user_d;
  logic [KW-1:0]   keep_q, keep_d;
  logic            last_q, last_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ovs_q, ovs_d;

  logic            hi_vld, lo_vld, pick_vld;
  logic [GW-1:0]   hi_id, lo_id, pick_id;
  logic            sel_valid, sel_last;
  logic [DW-1:0]   sel_data;
  logic [UW-1:0]   sel_user;
  logic [KW-1:0]   sel_keep;
  logic            allow, in_acc;
  logic [CW-1:0]   cnt_inc;

  // First requester strictly above the pointer wins, else the lowest at/below it.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int c = int'(P_CH_NUM) - 1; c >= 0; c--) begin
      if (s_axis_valid[c]) begin
        if (c > int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_id  = GW'(c);
        end else begin
          lo_vld = 1'b1;
          lo_id  = GW'(c);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_id  = hi_vld ? hi_id : lo_id;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_user  = '0;
    sel_keep  = '0;
    for (int c = 0; c < int'(P_CH_NUM); c++) begin
      if (c == int'(grant_q)) begin
        sel_valid = s_axis_valid[c];
        sel_last  = s_axis_last[c];
        sel_data  = s_axis_data[c*DW +: DW];
        sel_user  = s_axis_user[c*UW +: UW];
        sel_keep  = s_axis_keep[c*KW +: KW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    data_d       = data_q;
    user_d       = user_q;
    keep_d       = keep_q;
    last_d       = last_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    ovs_d        = ovs_q;
    s_axis_ready = '0;
    allow        = ~valid_q | m_axis_out_ready;
    in_acc       = 1'b0;
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    if (valid_q && m_axis_out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          ptr_d   = pick_id;
          grant_d = pick_id;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        for (int c = 0; c < int'(P_CH_NUM); c++) begin
          s_axis_ready[c] = (c == int'(grant_q)) && allow;
        end
        in_acc = sel_valid & allow;
        if (in_acc) begin
          data_d  = sel_data;
          user_d  = sel_user;
          keep_d  = sel_keep;
          last_d  = sel_last;
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
          if (sel_last) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            // Count includes the last beat itself.
            if ((cnt_inc > CW'(P_MAX_BEATS)) && (ovs_q != '1)) begin
              ovs_d = ovs_q + CW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= GW'(P_CH_NUM - 1);
      grant_q <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ovs_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      user_q  <= user_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ovs_q   <= ovs_d;
    end
  end

  assign m_axis_out_data  = data_q;
  assign m_axis_out_user  = user_q;
  assign m_axis_out_keep  = keep_q;
  assign m_axis_out_last  = last_q;
  assign m_axis_out_valid = valid_q;
  assign o_grant_id       = grant_q;
  assign o_busy           = busy_q;
  assign o_oversize_cnt   = ovs_q;

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Random-traffic bench for axis_rr_pkt_arbiter against a packet-level reference
// model (round-robin order, beat scoreboard, oversize count).
module tb_axis_rr_pkt_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXB = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [79:0] user;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [64*N-1:0]   s_data;
  logic [80*N-1:0]   s_user;
  logic [8*N-1:0]    s_keep;
  logic [N-1:0]      s_last;
  logic [N-1:0]      s_valid;
  logic [N-1:0]      s_ready;
  logic [63:0]       m_data;
  logic [79:0]       m_user;
  logic [7:0]        m_keep;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic [1:0]        o_grant_id;
  logic              o_busy;
  logic [15:0]       o_oversize_cnt;

  axis_rr_pkt_arbiter #(.P_CH_NUM(N), .P_MAX_BEATS(MAXB)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .s_axis_data      (s_data),
    .s_axis_user      (s_user),
    .s_axis_keep      (s_keep),
    .s_axis_last      (s_last),
    .s_axis_valid     (s_valid),
    .s_axis_ready     (s_ready),
    .m_axis_out_data  (m_data),
    .m_axis_out_user  (m_user),
    .m_axis_out_keep  (m_keep),
    .m_axis_out_last  (m_last),
    .m_axis_out_valid (m_valid),
    .m_axis_out_ready (m_ready),
    .o_grant_id       (o_grant_id),
    .o_busy           (o_busy),
    .o_oversize_cnt   (o_oversize_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Sources: one current beat per channel.
  beat_t cur[N];
  int    src_len[N];
  int    src_idx[N];
  bit    src_act[N];
  int    serial;
  bit    allow_new;
  bit    force_all;

  // Reference model state.
  beat_t       exp_q[$];
  bit          m_busy;
  int          m_g;
  int          m_ptr;
  logic [1:0]  m_gid;
  int          m_cnt;
  logic [15:0] m_ovs;

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic void new_beat(int c);
    cur[c].data = {8'(c), 8'(src_idx[c]), 16'(serial), 32'($urandom)};
    cur[c].last = (src_idx[c] == src_len[c] - 1);
    cur[c].keep = cur[c].last ? 8'($urandom) : 8'hFF;
  endfunction

  function automatic void start_pkt(int c);
    serial++;
    src_len[c] = int'($urandom_range(1, 7));
    src_idx[c] = 0;
    src_act[c] = 1'b1;
    cur[c].user = {16'(src_len[c]), 32'($urandom), 32'($urandom)};
    new_beat(c);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_busy = 1'b0;
    m_g    = 0;
    m_ptr  = int'(N) - 1;
    m_gid  = 2'd0;
    m_cnt  = 0;
    m_ovs  = 16'd0;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mvalid"}, 128'(m_valid), 128'(0));
    check({tag, "_mdata"},  128'(m_data), 128'(0));
    check({tag, "_muser"},  128'(m_user), 128'(0));
    check({tag, "_mkeep"},  128'(m_keep), 128'(0));
    check({tag, "_mlast"},  128'(m_last), 128'(0));
    check({tag, "_sready"}, 128'(s_ready), 128'(0));
    check({tag, "_busy"},   128'(o_busy), 128'(0));
    check({tag, "_gid"},    128'(o_grant_id), 128'(0));
    check({tag, "_ovs"},    128'(o_oversize_cnt), 128'(0));
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    bit           out_acc;
    bit           found;
    @(negedge i_clk);
    // Outputs as left by the previous rising edge.
    check("busy", 128'(o_busy), 128'(m_busy));
    check("grant_id", 128'(o_grant_id), 128'(m_gid));
    check("oversize", 128'(o_oversize_cnt), 128'(m_ovs));
    check("m_valid", 128'(m_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("m_data", 128'(m_data), 128'(exp_q[0].data));
      check("m_user", 128'(m_user), 128'(exp_q[0].user));
      check("m_keep", 128'(m_keep), 128'(exp_q[0].keep));
      check("m_last", 128'(m_last), 128'(exp_q[0].last));
    end
    // New stimulus for the coming edge.
    for (int c = 0; c < int'(N); c++) begin
      if (!src_act[c] && (force_all || (allow_new && $urandom_range(0, 3) == 0))) start_pkt(c);
      s_valid[c]          = src_act[c] && (force_all || $urandom_range(0, 7) != 0);
      s_data[64*c +: 64]  = cur[c].data;
      s_user[80*c +: 80]  = cur[c].user;
      s_keep[8*c +: 8]    = cur[c].keep;
      s_last[c]           = cur[c].last;
    end
    m_ready   = ($urandom_range(0, 9) < 7);
    force_all = 1'b0;
    #1;
    exp_rdy = '0;
    out_acc = (exp_q.size() != 0) && m_ready;
    if (m_busy && ((exp_q.size() == 0) || m_ready)) exp_rdy[m_g] = 1'b1;
    check("s_ready", 128'(s_ready), 128'(exp_rdy));
    if (out_acc) void'(exp_q.pop_front());
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= int'(N); k++) begin
        if (!found && s_valid[(m_ptr + k) % int'(N)]) begin
          found = 1'b1;
          m_g   = (m_ptr + k) % int'(N);
        end
      end
      if (found) begin
        m_ptr  = m_g;
        m_gid  = 2'(m_g);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    // Any handshake the DUT sees advances the source; wrong ready was flagged above.
    for (int c = 0; c < int'(N); c++) begin
      if (s_valid[c] && s_ready[c]) begin
        exp_q.push_back(cur[c]);
        m_cnt++;
        if (cur[c].last) begin
          if (m_cnt > int'(MAXB)) m_ovs = m_ovs + 16'd1;
          m_busy = 1'b0;
        end
        src_idx[c]++;
        if (src_idx[c] == src_len[c]) src_act[c] = 1'b0;
        else new_beat(c);
      end
    end
    check("queue_depth", 128'(exp_q.size() <= 1), 128'(1));
  endtask

  initial begin
    bit found;
    bit done;
    n_chk     = 0;
    n_pass    = 0;
    serial    = 0;
    allow_new = 1'b1;
    force_all = 1'b0;
    s_valid   = '0;
    s_data    = '0;
    s_user    = '0;
    s_keep    = '0;
    s_last    = '0;
    m_ready   = 1'b0;
    for (int c = 0; c < int'(N); c++) begin
      src_act[c] = 1'b0;
      src_len[c] = 1;
      src_idx[c] = 0;
      cur[c]     = '0;
    end
    model_reset();

    #2 i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    check_outputs_zero("reset");
    i_rst = 1'b0;

    repeat (1500) step();

    // Reset in the middle of a packet.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (m_busy && m_cnt >= 2) found = 1'b1;
    end
    check("rst_wait", 128'(found), 128'(1));
    i_rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    model_reset();
    for (int c = 0; c < int'(N); c++) src_act[c] = 1'b0;
    s_valid = '0;
    @(negedge i_clk);
    i_rst     = 1'b0;
    force_all = 1'b1;
    step();
    @(posedge i_clk);
    #1;
    check("first_grant_id", 128'(o_grant_id), 128'(0));
    check("first_grant_busy", 128'(o_busy), 128'(1));

    repeat (800) step();

    allow_new = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      step();
      done = !m_busy && (exp_q.size() == 0);
      for (int c = 0; c < int'(N); c++) if (src_act[c]) done = 1'b0;
    end
    check("drain", 128'(done), 128'(1));
    check("ovs_nonzero", 128'(o_oversize_cnt != 16'd0), 128'(m_ovs != 16'd0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
